// File: rtl/fetch_queue_if.sv
// Signal bundle between the fetch queue, instruction memory and decode.
// Handshakes: a fetch is accepted on a clk_en edge with inst_req & inst_ack; responses return in request order on inst_rvalid; decode takes the head on a clk_en edge with out_valid & out_ready.
interface fetch_queue_if #(parameter int DEPTH = 4);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          jmp;
  logic [29:0]   jmp_target;
  logic          inst_req;
  logic [29:0]   inst_address;
  logic          inst_ack;
  logic          inst_rvalid;
  logic [31:0]   inst_rdata;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_inst;
  logic [29:0]   out_pc;
  logic [CW-1:0] occupancy;

  modport master (
    input  jmp, jmp_target, inst_ack, inst_rvalid, inst_rdata, out_ready,
    output inst_req, inst_address, out_valid, out_inst, out_pc, occupancy
  );

  modport slave (
    output jmp, jmp_target, inst_ack, inst_rvalid, inst_rdata, out_ready,
    input  inst_req, inst_address, out_valid, out_inst, out_pc, occupancy
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction prefetch queue: pipelined in-order word fetches into a shift-register FIFO
// whose entry 0 is the registered head seen by decode; jmp flushes buffered and in-flight fetches.
module fetch_queue #(
  parameter int          DEPTH         = 4,
  parameter logic [29:0] RESET_ADDRESS = 30'h0
) (
  input logic           clk,
  input logic           clk_en,
  input logic           sync_rst,
  fetch_queue_if.master bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = CW + 2;
  localparam logic [SW-1:0] DEPTH_S = SW'(DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  logic [29:0]   fetch_pc_q, fetch_pc_d;
  logic [29:0]   resp_pc_q, resp_pc_d;
  logic [CW-1:0] count_q, count_d;
  logic [CW-1:0] live_q, live_d;
  logic [CW-1:0] stale_q, stale_d;
  logic [29:0]   pc_q   [DEPTH];
  logic [29:0]   pc_d   [DEPTH];
  logic [31:0]   inst_q [DEPTH];
  logic [31:0]   inst_d [DEPTH];

  logic          req, acc, resp, drop, push, pop;
  logic [SW-1:0] credit;
  logic [CW-1:0] wr_idx;
  logic [31:0]   swapped;

  always_comb begin
    credit  = SW'(count_q) + SW'(live_q) + SW'(stale_q);
    req     = clk_en & ~sync_rst & ~bus.jmp & (credit < DEPTH_S);
    acc     = req & bus.inst_ack;
    resp    = clk_en & bus.inst_rvalid;
    drop    = resp & (stale_q != '0);
    push    = resp & (stale_q == '0) & (live_q != '0);
    pop     = clk_en & (count_q != '0) & bus.out_ready;
    swapped = {bus.inst_rdata[7:0], bus.inst_rdata[15:8],
               bus.inst_rdata[23:16], bus.inst_rdata[31:24]};
    // With a pop the entries shift down one, so the new word lands one slot lower.
    wr_idx  = pop ? (count_q - CW'(1)) : count_q;

    fetch_pc_d = fetch_pc_q;
    resp_pc_d  = resp_pc_q;
    count_d    = count_q;
    live_d     = live_q;
    stale_d    = stale_q;
    pc_d       = pc_q;
    inst_d     = inst_q;

    if (clk_en) begin
      if (bus.jmp) begin
        count_d    = '0;
        live_d     = '0;
        fetch_pc_d = bus.jmp_target;
        resp_pc_d  = bus.jmp_target;
        stale_d    = stale_q + live_q - CW'(drop | push);
      end else begin
        fetch_pc_d = fetch_pc_q + 30'(acc);
        resp_pc_d  = resp_pc_q + 30'(push);
        live_d     = live_q + CW'(acc) - CW'(push);
        stale_d    = stale_q - CW'(drop);
        count_d    = count_q + CW'(push) - CW'(pop);
        for (int i = 0; i < DEPTH - 1; i++) begin
          if (pop) begin
            pc_d[i]   = pc_q[i+1];
            inst_d[i] = inst_q[i+1];
          end
        end
        for (int i = 0; i < DEPTH; i++) begin
          if (push && (wr_idx == CW'(i))) begin
            pc_d[i]   = resp_pc_q;
            inst_d[i] = swapped;
          end
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (sync_rst) begin
      fetch_pc_q <= RESET_ADDRESS;
      resp_pc_q  <= RESET_ADDRESS;
      count_q    <= '0;
      live_q     <= '0;
      stale_q    <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]   <= RESET_ADDRESS;
        inst_q[i] <= '0;
      end
    end else begin
      fetch_pc_q <= fetch_pc_d;
      resp_pc_q  <= resp_pc_d;
      count_q    <= count_d;
      live_q     <= live_d;
      stale_q    <= stale_d;
      pc_q       <= pc_d;
      inst_q     <= inst_d;
    end
  end

  assign bus.inst_req     = req;
  assign bus.inst_address = fetch_pc_q;
  assign bus.out_valid    = (count_q != '0);
  assign bus.out_inst     = inst_q[0];
  assign bus.out_pc       = pc_q[0];
  assign bus.occupancy    = count_q;

  // The credit limit makes a push into a full queue impossible.
  a_no_overflow: assert property (@(posedge clk) disable iff (sync_rst)
    !(push && (count_q == DEPTH_C)));
  a_no_orphan_resp: assert property (@(posedge clk) disable iff (sync_rst)
    !(resp && (live_q == '0) && (stale_q == '0)));
endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: in-order memory model with configurable latency plus a queue-level reference of the decode-side stream.
module tb_fetch_queue;
  localparam int          DEPTH = 4;
  localparam int          CW    = $clog2(DEPTH) + 1;
  localparam logic [29:0] RA_W  = 30'h3FFFFFFE;

  // clock / reset block
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        clk_en, sync_rst, jmp, inst_ack, inst_rvalid, out_ready;
  logic [29:0] jmp_target;
  logic [31:0] inst_rdata;
  logic        sel_w;

  fetch_queue_if #(.DEPTH(DEPTH)) bus_a ();
  fetch_queue_if #(.DEPTH(DEPTH)) bus_w ();

  assign bus_a.jmp = jmp;           assign bus_w.jmp = jmp;
  assign bus_a.jmp_target = jmp_target; assign bus_w.jmp_target = jmp_target;
  assign bus_a.inst_ack = inst_ack; assign bus_w.inst_ack = inst_ack;
  assign bus_a.inst_rvalid = inst_rvalid; assign bus_w.inst_rvalid = inst_rvalid;
  assign bus_a.inst_rdata = inst_rdata;   assign bus_w.inst_rdata = inst_rdata;
  assign bus_a.out_ready = out_ready;     assign bus_w.out_ready = out_ready;

  fetch_queue #(.DEPTH(DEPTH), .RESET_ADDRESS(30'h0)) u_dut (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .bus(bus_a.master));
  fetch_queue #(.DEPTH(DEPTH), .RESET_ADDRESS(RA_W)) u_dut_w (
    .clk(clk), .clk_en(clk_en), .sync_rst(sync_rst), .bus(bus_w.master));

  logic          f_req, f_valid;
  logic [29:0]   f_addr, f_pc;
  logic [31:0]   f_inst;
  logic [CW-1:0] f_occ;
  assign f_req   = sel_w ? bus_w.inst_req     : bus_a.inst_req;
  assign f_addr  = sel_w ? bus_w.inst_address : bus_a.inst_address;
  assign f_valid = sel_w ? bus_w.out_valid    : bus_a.out_valid;
  assign f_pc    = sel_w ? bus_w.out_pc       : bus_a.out_pc;
  assign f_inst  = sel_w ? bus_w.out_inst     : bus_a.out_inst;
  assign f_occ   = sel_w ? bus_w.occupancy    : bus_a.occupancy;

  // memory model: outstanding fetches in order, each with data, keep flag, remaining wait
  logic [29:0] oq_addr[$];
  logic [31:0] oq_data[$];
  bit          oq_keep[$];
  int          oq_wait[$];
  // scoreboard: what decode should see, in order
  logic [29:0] exp_q[$];
  logic [31:0] exp_inst_q[$];

  logic [29:0] m_fetch_pc;
  int          lat;
  bit          ack_rand, data_stream;
  logic        exp_req, obs_req;
  logic [29:0] exp_addr, obs_addr;
  int          n_checks, n_fail;

  function automatic logic [31:0] bswap(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  // One clock: drive inputs, capture the request, advance the reference at the edge, settle.
  task automatic tick(input logic en_v, input logic rst_v, input logic jmp_v,
                      input logic [29:0] tgt, input logic rdy_v);
    logic        rv, keep_h;
    logic [29:0] a_h;
    clk_en = en_v; sync_rst = rst_v; jmp = jmp_v; jmp_target = tgt; out_ready = rdy_v;
    rv = (oq_addr.size() > 0) && (oq_wait[0] == 0);
    inst_rvalid = rv;
    inst_rdata  = rv ? oq_data[0] : $urandom();
    inst_ack    = ack_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    #1;
    exp_req  = en_v && !rst_v && !jmp_v && ((exp_q.size() + oq_addr.size()) < DEPTH);
    exp_addr = m_fetch_pc;
    obs_req  = f_req;
    obs_addr = f_addr;
    @(posedge clk);
    if (rst_v) begin
      exp_q.delete(); exp_inst_q.delete();
      oq_addr.delete(); oq_data.delete(); oq_keep.delete(); oq_wait.delete();
      m_fetch_pc = sel_w ? RA_W : 30'h0;
    end else if (en_v) begin
      keep_h = 1'b0;
      a_h    = '0;
      if (rv) begin
        keep_h = oq_keep[0];
        a_h    = oq_addr[0];
        void'(oq_addr.pop_front()); void'(oq_data.pop_front());
        void'(oq_keep.pop_front()); void'(oq_wait.pop_front());
      end
      foreach (oq_wait[i]) if (oq_wait[i] > 0) oq_wait[i] = oq_wait[i] - 1;
      if (jmp_v) begin
        exp_q.delete(); exp_inst_q.delete();
        foreach (oq_keep[i]) oq_keep[i] = 1'b0;
        m_fetch_pc = tgt;
      end else begin
        if (exp_q.size() > 0 && rdy_v) begin
          void'(exp_q.pop_front()); void'(exp_inst_q.pop_front());
        end
        if (rv && keep_h) begin
          exp_q.push_back(a_h);
          exp_inst_q.push_back(bswap(inst_rdata));
        end
        if (exp_req && inst_ack) begin
          oq_addr.push_back(m_fetch_pc);
          oq_data.push_back(data_stream ? (32'h13000000 + {2'b00, m_fetch_pc}) : $urandom());
          oq_keep.push_back(1'b1);
          oq_wait.push_back(lat - 1);
          m_fetch_pc = m_fetch_pc + 30'd1;
        end
      end
    end
    #1;
  endtask

  task automatic setup(input bit w, input int l, input bit ar, input bit ds);
    sel_w = w; lat = l; ack_rand = ar; data_stream = ds;
    tick(1'b1, 1'b1, 1'b0, 30'h0, 1'b1);
  endtask

  task automatic test_reset();
    setup(1'b0, 1, 1'b0, 1'b1);
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b want 0", obs_req); end
    n_checks++; if (f_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", f_valid); end
    n_checks++; if (f_occ !== '0) begin n_fail++; $display("FAIL reset_occ: got %0d want 0", f_occ); end
    n_checks++; if (f_inst !== 32'h0) begin n_fail++; $display("FAIL reset_inst: got %h want 0", f_inst); end
    n_checks++; if (f_pc !== 30'h0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", f_pc); end
    n_checks++; if (f_addr !== 30'h0) begin n_fail++; $display("FAIL reset_addr: got %h want 0", f_addr); end
    sel_w = 1'b1; #0;
    n_checks++; if (f_pc !== RA_W || f_addr !== RA_W) begin n_fail++; $display("FAIL reset_ra: got pc %h addr %h want %h", f_pc, f_addr, RA_W); end
  endtask

  task automatic test_streaming();
    setup(1'b0, 1, 1'b0, 1'b1);
    for (int k = 1; k <= 12; k++) begin
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      n_checks++;
      if (obs_req !== 1'b1 || obs_addr !== 30'(k - 1)) begin
        n_fail++; $display("FAIL stream_req c%0d: got %b/%h want 1/%h", k, obs_req, obs_addr, 30'(k - 1));
      end
      if (k >= 2) begin
        n_checks++;
        if (f_valid !== 1'b1 || f_pc !== 30'(k - 2) || f_occ !== CW'(1)) begin
          n_fail++; $display("FAIL stream_out c%0d: got v%b pc %h occ %0d want v1 pc %h occ 1", k + 1, f_valid, f_pc, f_occ, 30'(k - 2));
        end
      end
      if (k == 2) begin
        n_checks++; if (f_inst !== 32'h00000013) begin n_fail++; $display("FAIL stream_inst0: got %h want 00000013", f_inst); end
      end
      if (k == 3) begin
        n_checks++; if (f_inst !== 32'h01000013) begin n_fail++; $display("FAIL stream_inst1: got %h want 01000013", f_inst); end
      end
    end
  endtask

  task automatic test_backpressure();
    int n_req;
    logic [29:0] seen[$];
    setup(1'b0, 1, 1'b0, 1'b1);
    n_req = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b0);
      if (obs_req === 1'b1) n_req++;
    end
    n_checks++; if (n_req != 4) begin n_fail++; $display("FAIL bp_reqs: got %0d want 4", n_req); end
    n_checks++; if (f_occ !== CW'(4)) begin n_fail++; $display("FAIL bp_occ: got %0d want 4", f_occ); end
    n_checks++; if (obs_req !== 1'b0) begin n_fail++; $display("FAIL bp_req_low: got %b want 0", obs_req); end
    for (int k = 0; k < 12; k++) begin
      if (f_valid === 1'b1) seen.push_back(f_pc);
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
    end
    n_checks++;
    if (seen.size() < 6) begin
      n_fail++; $display("FAIL bp_drain_len: got %0d want >=6", seen.size());
    end else begin
      for (int i = 0; i < 6; i++)
        if (seen[i] !== 30'(i)) begin n_fail++; $display("FAIL bp_drain_pc[%0d]: got %h want %h", i, seen[i], 30'(i)); break; end
    end
  endtask

  task automatic test_flush();
    logic [29:0] stale_set[$];
    bit found, got_first;
    setup(1'b0, 2, 1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      if (oq_addr.size() == 2) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL flush_setup: got no 2-outstanding point want one"); end
    stale_set = oq_addr;
    tick(1'b1, 1'b0, 1'b1, 30'h100, 1'b1);
    n_checks++; if (f_valid !== 1'b0 || f_occ !== '0) begin n_fail++; $display("FAIL flush_empty: got v%b occ %0d want v0 occ 0", f_valid, f_occ); end
    tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
    n_checks++; if (obs_req !== 1'b1 || obs_addr !== 30'h100) begin n_fail++; $display("FAIL flush_req: got %b/%h want 1/100", obs_req, obs_addr); end
    got_first = 0;
    for (int k = 0; k < 10; k++) begin
      if (f_valid === 1'b1) begin
        foreach (stale_set[i]) if (f_pc === stale_set[i]) begin
          n_fail++; $display("FAIL flush_stale_seen: got pc %h want none of stale", f_pc);
        end
        if (!got_first) begin
          got_first = 1; n_checks++;
          if (f_pc !== 30'h100) begin n_fail++; $display("FAIL flush_first_pc: got %h want 100", f_pc); end
        end
      end
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
    end
    n_checks++; if (!got_first) begin n_fail++; $display("FAIL flush_no_output: got none want pc 100"); end
  endtask

  task automatic test_simultaneous();
    bit found;
    setup(1'b0, 2, 1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 30 && !found; k++) begin
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      if (exp_q.size() > 0 && oq_addr.size() >= 2 && oq_wait[0] == 0) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL simul_setup: got no point want rvalid+nonempty"); end
    tick(1'b1, 1'b0, 1'b1, 30'h2A0, 1'b1);
    n_checks++; if (f_valid !== 1'b0 || f_occ !== '0) begin n_fail++; $display("FAIL simul_empty: got v%b occ %0d want v0 occ 0", f_valid, f_occ); end
    for (int k = 0; k < 10; k++) begin
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b1);
      n_checks++;
      if (f_occ !== CW'(exp_q.size()) || (exp_q.size() > 0 && f_pc !== exp_q[0])) begin
        n_fail++; $display("FAIL simul_after: got occ %0d pc %h want occ %0d", f_occ, f_pc, exp_q.size());
      end
    end
  endtask

  task automatic test_wrap_clk_en();
    logic [29:0] seen[$];
    logic [29:0] hold_pc;
    logic [CW-1:0] hold_occ;
    logic en;
    setup(1'b1, 1, 1'b0, 1'b1);
    for (int k = 0; k < 16; k++) begin
      en = !(k >= 6 && k <= 8);
      if (en && f_valid === 1'b1) seen.push_back(f_pc);
      hold_pc = f_pc; hold_occ = f_occ;
      tick(en, 1'b0, 1'b0, 30'h0, 1'b1);
      if (!en) begin
        n_checks++;
        if (obs_req !== 1'b0 || f_pc !== hold_pc || f_occ !== hold_occ) begin
          n_fail++; $display("FAIL clken_hold k%0d: got req %b pc %h occ %0d want req 0 pc %h occ %0d", k, obs_req, f_pc, f_occ, hold_pc, hold_occ);
        end
      end
    end
    n_checks++;
    if (seen.size() < 8) begin
      n_fail++; $display("FAIL wrap_len: got %0d want >=8", seen.size());
    end else begin
      for (int i = 0; i < 8; i++)
        if (seen[i] !== RA_W + 30'(i)) begin n_fail++; $display("FAIL wrap_pc[%0d]: got %h want %h", i, seen[i], RA_W + 30'(i)); break; end
    end
  endtask

  task automatic test_reset_mid();
    bit found;
    setup(1'b0, 1, 1'b0, 1'b1);
    found = 0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick(1'b1, 1'b0, 1'b0, 30'h0, 1'b0);
      if (exp_q.size() == 3 && oq_addr.size() == 1) found = 1;
    end
    n_checks++; if (!found) begin n_fail++; $display("FAIL rstmid_setup: got no 3+1 point want one"); end
    tick(1'b1, 1'b1, 1'b0, 30'h0, 1'b1);
    n_checks++;
    if (f_occ !== '0 || f_valid !== 1'b0 || f_addr !== 30'h0) begin
      n_fail++; $display("FAIL rstmid: got occ %0d v%b addr %h want 0 0 0", f_occ, f_valid, f_addr);
    end
  endtask

  task automatic test_random();
    logic en, rs, jp, rdy;
    for (int l = 1; l <= 2; l++) begin
      setup(1'b0, l, 1'b1, 1'b0);
      for (int k = 0; k < 400; k++) begin
        en  = ($urandom_range(0, 7) != 0);
        rs  = ($urandom_range(0, 149) == 0);
        jp  = ($urandom_range(0, 11) == 0);
        rdy = ($urandom_range(0, 3) != 0);
        tick(en, rs, jp, 30'($urandom()), rdy);
        n_checks++; if (obs_req !== exp_req) begin n_fail++; $display("FAIL rnd_req: got %b want %b", obs_req, exp_req); end
        if (exp_req) begin
          n_checks++; if (obs_addr !== exp_addr) begin n_fail++; $display("FAIL rnd_addr: got %h want %h", obs_addr, exp_addr); end
        end
        n_checks++; if (f_occ !== CW'(exp_q.size())) begin n_fail++; $display("FAIL rnd_occ: got %0d want %0d", f_occ, exp_q.size()); end
        n_checks++; if (f_valid !== (exp_q.size() != 0)) begin n_fail++; $display("FAIL rnd_valid: got %b want %b", f_valid, exp_q.size() != 0); end
        if (exp_q.size() != 0) begin
          n_checks++;
          if (f_pc !== exp_q[0] || f_inst !== exp_inst_q[0]) begin
            n_fail++; $display("FAIL rnd_head: got %h/%h want %h/%h", f_pc, f_inst, exp_q[0], exp_inst_q[0]);
          end
        end
      end
    end
  endtask

  initial begin
    n_checks = 0; n_fail = 0;
    sel_w = 1'b0; lat = 1; ack_rand = 1'b0; data_stream = 1'b1; m_fetch_pc = '0;
    clk_en = 1'b0; sync_rst = 1'b1; jmp = 1'b0; jmp_target = '0;
    inst_ack = 1'b0; inst_rvalid = 1'b0; inst_rdata = '0; out_ready = 1'b0;
    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_simultaneous();
    test_wrap_clk_en();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Parametrised instruction prefetch queue. It replaces the single-register fetch stage between instruction memory and decode, and decouples the two.
- Issues pipelined word fetches to an instruction memory with a request/acknowledge and in-order response handshake.
- Buffers up to DEPTH returned instructions, each tagged with its PC.
- Presents them to decode with a valid/ready handshake.
- On a jump from the memory stage, flushes all buffered and in-flight fetches.

## Interface
- DEPTH, 4: queue entries and maximum in-flight fetches; power of two, ≥2.
- RESET_ADDRESS, 30'h0: word address fetched first after reset.

- clk  in  1  clock
- clk_en  in  1  global clock enable; low freezes all state and forces inst_req low
- sync_rst  in  1  reset; one clock; synchronous, active-high
- jmp  in  1  redirect/flush (taken branch, jump, ECALL)
- jmp_target  in  30  new word address
- inst_req  out  1  fetch request
- inst_address  out  30  word address of request
- inst_ack  in  1  memory accepts request this cycle
- inst_rvalid  in  1  response data valid; responses return in request order
- inst_rdata  in  32  response word, little endian
- out_valid  out  1  head entry valid
- out_ready  in  1  decode accepts head (decode not stalled)
- out_inst  out  32  head instruction, byte-reversed: {rdata[7:0],rdata[15:8],rdata[23:16],rdata[31:24]}
- out_pc  out  30  head word address
- occupancy  out  $clog2(DEPTH)+1  valid entries in queue

## Operation
- State:
  - fetch_pc: next request address.
  - resp_pc: tag for the next accepted response.
  - live: in-flight requests whose responses will be kept.
  - stale: in-flight requests whose responses will be discarded.
  - FIFO of {pc, inst}, count 0..DEPTH.
- inst_req = clk_en & !sync_rst & !jmp & (count + live + stale < DEPTH). inst_address = fetch_pc.
- Accepted request (inst_req & inst_ack): fetch_pc += 1, with mod 2^30 wrap; live += 1.
- Response (inst_rvalid & clk_en):
  - If stale > 0: stale -= 1 and drop the data.
  - Else: push {resp_pc, byte-reversed rdata}; resp_pc += 1 (wraps); live -= 1.
- Pop when out_valid & out_ready. Push and pop in the same cycle leave count unchanged.
- jmp (clk_en high) has priority over everything that cycle:
  - FIFO cleared (count = 0); a pop that cycle is ignored.
  - fetch_pc = resp_pc = jmp_target.
  - stale = stale + live − inst_rvalid; live = 0.
  - No request is issued in the jmp cycle.
- Credit rule (count + live + stale ≤ DEPTH) guarantees a response can never find the FIFO full. Overflow is impossible by construction; an assertion flags a push at count == DEPTH.
- Responses with inst_rvalid high while live = stale = 0 are a protocol error. They are ignored and flagged by an assertion.

## Timing
- Reset (sync_rst high at a rising edge):
  - count = live = stale = 0; fetch_pc = resp_pc = RESET_ADDRESS.
  - Outputs: out_valid 0, out_inst 0, out_pc RESET_ADDRESS, occupancy 0, inst_address RESET_ADDRESS.
  - inst_req is 0 while sync_rst is high.
  - Reset mid-operation discards in-flight bookkeeping. The memory must drop outstanding responses on the same reset.
- First request: the cycle after sync_rst deasserts.
- Latency: rvalid in cycle N → out_valid/out_inst/out_pc in cycle N+1 (registered FIFO, show-ahead head).
- Throughput: one instruction per cycle with single-cycle memory (ack always 1, rvalid one cycle after ack) and out_ready held high.
- jmp in cycle N:
  - out_valid is 0 in N+1.
  - First request to jmp_target is issued in N+1.
  - Earliest valid output is N+3 with single-cycle memory.
- clk_en low: all registers hold; inst_req = 0; inst_rvalid/inst_ack are ignored. Memory shares clk_en.
- Outputs out_* and occupancy come straight from registers. inst_req is combinational from registered state plus jmp, clk_en and sync_rst.

## Test plan
- Streaming: reset, ack=1, rvalid one cycle after ack, rdata = 0x13000000+pc, out_ready=1.
  - out_pc = 0,1,2,… each cycle from cycle 3.
  - out_inst byte-reversed: rdata 0x13000000 → out_inst 0x00000013.
- Backpressure: DEPTH=4, out_ready=0.
  - Exactly 4 requests issue; occupancy reaches 4; inst_req stays 0.
  - Release out_ready → pcs 0..3 drain in order, then fetching resumes at pc 4.
- Flush with in-flight fetches: 2-cycle memory latency, 2 requests outstanding, jmp with jmp_target=0x100.
  - The two stale responses are dropped.
  - Next out_pc = 0x100; no pc 2/3 ever appears on out_*.
- Simultaneous events:
  - jmp in the same cycle as rvalid and out_ready=1 → FIFO empty next cycle, stale = live−1, no pop counted.
  - Push and pop in the same cycle → occupancy unchanged.
- Wrap and clk_en: RESET_ADDRESS=30'h3FFFFFFE, streaming.
  - out_pc = 3FFFFFFE, 3FFFFFFF, 0, 1.
  - clk_en low for 3 cycles mid-stream → no request, no state change, sequence resumes unbroken.
- Reset mid-operation: sync_rst with 3 entries queued and 1 in flight → next cycle occupancy 0, out_valid 0, inst_address = RESET_ADDRESS.
